wb_ram_arbiter: RTL

Two-port Wishbone (classic, non-pipelined) front end that shares one single-port, byte-writable SRAM macro between two independent requesters, port A and port B.
- Arbitrates between the ports and sequences each RAM access: enable/write strobe, read-latency wait, registered ack.
- Sits between the SoC Wishbone masters and the RAM macro, in place of a true dual-port RAM.

---
 rtl/wb_ram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two Wishbone ports sharing one byte-writable single-port SRAM; define WB_RAM_ARB_FIXED_PRIO_EN for fixed A priority
module wb_ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8
) (
    input  logic              wb_clk,
    input  logic              wb_reset_n,
    input  logic              pA_wb_cyc_i,
    input  logic              pA_wb_stb_i,
    input  logic              pA_wb_we_i,
    input  logic [SEL_W-1:0]  pA_wb_sel_i,
    input  logic [ADDR_W-1:0] pA_wb_adr_i,
    input  logic [DATA_W-1:0] pA_wb_dat_i,
    output logic              pA_wb_ack_o,
    output logic [DATA_W-1:0] pA_wb_dat_o,
    input  logic              pB_wb_cyc_i,
    input  logic              pB_wb_stb_i,
    input  logic              pB_wb_we_i,
    input  logic [SEL_W-1:0]  pB_wb_sel_i,
    input  logic [ADDR_W-1:0] pB_wb_adr_i,
    input  logic [DATA_W-1:0] pB_wb_dat_i,
    output logic              pB_wb_ack_o,
    output logic [DATA_W-1:0] pB_wb_dat_o,
    output logic              ram_en_o,
    output logic [SEL_W-1:0]  ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic grant_q, grant_d, last_grant_q, last_grant_d, we_q, we_d;
    logic ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d, dat_a_q, dat_a_d, dat_b_q, dat_b_d;
    logic req_a, req_b, pick_b, gnt_cyc;
    assign req_a = pA_wb_cyc_i && pA_wb_stb_i;
    assign req_b = pB_wb_cyc_i && pB_wb_stb_i;
`ifdef WB_RAM_ARB_FIXED_PRIO_EN
    assign pick_b = !req_a;
`else
    // grant/last_grant encode 0 = A, 1 = B; on contention B wins only if A went last
    assign pick_b = req_b && (!req_a || !last_grant_q);
`endif
    assign gnt_cyc = grant_q ? pB_wb_cyc_i : pA_wb_cyc_i;
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_grant_d = last_grant_q;
        we_d = we_q;
        sel_d = sel_q;
        adr_d = adr_q;
        dat_d = dat_q;
        ack_a_d = ack_a_q;
        ack_b_d = ack_b_q;
        dat_a_d = dat_a_q;
        dat_b_d = dat_b_q;
        ram_en_o = 1'b0;
        ram_we_o = '0;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    grant_d = pick_b;
                    last_grant_d = pick_b;
                    we_d = pick_b ? pB_wb_we_i : pA_wb_we_i;
                    sel_d = pick_b ? pB_wb_sel_i : pA_wb_sel_i;
                    adr_d = pick_b ? pB_wb_adr_i : pA_wb_adr_i;
                    dat_d = pick_b ? pB_wb_dat_i : pA_wb_dat_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_en_o = 1'b1;
                ram_we_o = we_q ? sel_q : '0;
                state_d = gnt_cyc ? WAIT : IDLE;
            end
            WAIT: begin
                state_d = gnt_cyc ? DONE : IDLE;
                if (gnt_cyc) begin
                    ack_a_d = !grant_q;
                    ack_b_d = grant_q;
                    dat_a_d = (!grant_q && !we_q) ? ram_dout_i : dat_a_q;
                    dat_b_d = (grant_q && !we_q) ? ram_dout_i : dat_b_q;
                end
            end
            DONE: begin
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk) begin
        if (!wb_reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_grant_q <= 1'b1;
            we_q <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            dat_a_q <= '0;
            dat_b_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_grant_q <= last_grant_d;
            we_q <= we_d;
            sel_q <= sel_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            dat_a_q <= dat_a_d;
            dat_b_q <= dat_b_d;
        end
    end
    assign pA_wb_ack_o = ack_a_q;
    assign pB_wb_ack_o = ack_b_q;
    assign pA_wb_dat_o = dat_a_q;
    assign pB_wb_dat_o = dat_b_q;
    assign ram_addr_o = adr_q;
    assign ram_din_o = dat_q;
endmodule
